// File: rtl/dm_if.sv
// rtl/dm_if.sv - request/response bus between an initiator and dm_responder
//
// Purpose: bundles the chip-select style request fields and the response
// signals of the word-storage responder.
// Signals:
//   req_cs     request strobe (chip select)
//   req_oe     read enable
//   req_web    per-byte write enable, active-low (4'b1111 = no write)
//   req_addr   word address
//   req_wdata  write data, byte i = bits 8i+7:8i
//   busy       stall back to the initiator; request fields held while high
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data
//   rsp_err    out-of-range flag, meaningful with rsp_valid
// Modports: master = initiator side, slave = responder side.
interface dm_if;
   logic        req_cs;
   logic        req_oe;
   logic [3:0]  req_web;
   logic [13:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_cs, req_oe, req_web, req_addr, req_wdata,
      input  busy, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_cs, req_oe, req_web, req_addr, req_wdata,
      output busy, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - word-storage responder with programmable wait states
//
// Purpose: accepts one request at a time, inserts WAIT_CYCLES wait states,
// commits a byte-masked write or a word read to 2**DEPTH_LOG2 x 32-bit
// storage, then pulses a one-cycle response.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset (storage is not cleared)
//   bus  dm_if.slave: req_cs/req_oe/req_web/req_addr/req_wdata in,
//        busy/rsp_valid/rsp_rdata/rsp_err out
module dm_responder #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   dm_if.slave bus
);
   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [13:0] addr_q;
   logic [3:0]  web_q;
   logic        oe_q;
   logic [31:0] wdata_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [31:0] mem [DEPTH];

   // Fields used by the commit. With zero wait states the commit happens on
   // the acceptance edge itself, so the live inputs are used then.
   logic [13:0]           c_addr;
   logic [3:0]            c_web;
   logic                  c_oe;
   logic [31:0]           c_wdata;
   logic [DEPTH_LOG2-1:0] c_idx;
   logic                  c_oor;
   logic                  c_rd;
   logic                  commit;
   logic                  mem_we;

   always_comb begin
      if (state == IDLE) begin
         c_addr  = bus.req_addr;
         c_web   = bus.req_web;
         c_oe    = bus.req_oe;
         c_wdata = bus.req_wdata;
      end else begin
         c_addr  = addr_q;
         c_web   = web_q;
         c_oe    = oe_q;
         c_wdata = wdata_q;
      end
      c_idx  = c_addr[DEPTH_LOG2-1:0];
      c_oor  = (c_addr >> DEPTH_LOG2) != 14'd0;
      // Any low web bit makes it a write, which wins over oe.
      c_rd   = c_oe && (c_web == 4'b1111);
      if (WAIT_CYCLES == 0)
         commit = (state == IDLE) && bus.req_cs;
      else
         commit = (state == WAIT) && (cnt == 4'd1);
      // rst is sampled here too so an edge under reset never writes.
      mem_we = commit && !rst && !c_oor && (c_web != 4'b1111);
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (!c_web[i])
               mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         addr_q      <= 14'd0;
         web_q       <= 4'b1111;
         oe_q        <= 1'b0;
         wdata_q     <= 32'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_cs) begin
                  addr_q  <= bus.req_addr;
                  web_q   <= bus.req_web;
                  oe_q    <= bus.req_oe;
                  wdata_q <= bus.req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= RESP;
            end
            RESP: begin
               state     <= IDLE;
               rsp_err_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // Read data is the pre-commit word: the write lands on this same edge.
         if (commit) begin
            rsp_rdata_q <= (c_rd && !c_oor) ? mem[c_idx] : 32'd0;
            rsp_err_q   <= c_oor;
         end
      end
   end

   assign bus.busy      = (state == WAIT) || ((state == IDLE) && bus.req_cs);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, SHALL set word-storage size to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set wait states inserted before each response.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_cs  input  1  request strobe from initiator, chip select.
REQ-007 req_oe  input  1  read enable.
REQ-008 req_web  input  4  per-byte write enable, active-low; 4'b1111 = no write.
REQ-009 req_addr  input  14  word address.
REQ-010 req_wdata  input  32  write data, byte i = bits 8i+7:8i.
REQ-011 busy  output  1  stall to initiator; initiator holds request fields while high.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  read data.
REQ-014 rsp_err  output  1  out-of-range flag, valid with rsp_valid.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 IDLE with req_cs=1 SHALL accept: latch addr, web, oe, wdata; go to WAIT with cnt=WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement cnt each cycle; when cnt==1 it SHALL commit the access and go to RESP.
REQ-018 RESP SHALL last exactly one cycle, then go to IDLE; req_cs in RESP or WAIT SHALL be ignored.
REQ-019 Latency: accepted at edge T -> rsp_valid high for the cycle after edge T+WAIT_CYCLES (T+1 when WAIT_CYCLES=0).
REQ-020 busy SHALL be combinational: 1 when state==WAIT, or state==IDLE and req_cs==1; else 0; busy=0 in RESP.
REQ-021 rsp_valid SHALL equal (state==RESP).
REQ-022 Commit write: for each i with web[i]==0, byte i of word[addr[DEPTH_LOG2-1:0]] SHALL take wdata byte i; other bytes unchanged.
REQ-023 Commit read: when oe==1 and web==4'b1111, rsp_rdata SHALL load pre-commit word contents; otherwise rsp_rdata SHALL load 0.
REQ-024 Simultaneous oe==1 and any web bit low: write SHALL take priority; rsp_rdata SHALL load 0.
REQ-025 Out of range (req_addr[13:DEPTH_LOG2] != 0): no write, rsp_rdata=0, rsp_err=1 in RESP.
REQ-026 cs with oe=0 and web=4'b1111 SHALL traverse the FSM as a no-op: rsp_rdata=0, rsp_err=0.
REQ-027 rsp_rdata SHALL hold its value between responses; rsp_err SHALL be 0 outside RESP.
REQ-028 Latched request fields SHALL stay stable from acceptance to commit, regardless of input changes.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; busy then follows req_cs.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset asserted before the commit edge SHALL abort the access with no write performed.

Verification
REQ-032 WAIT_CYCLES=2: write web=4'b0000 addr 5 data 32'hDEADBEEF at edge 0 -> busy high cycles 0-2, rsp_valid high in cycle 3; read addr 5 -> rsp_rdata=32'hDEADBEEF.
REQ-033 Byte lanes: word 7 = 32'h11223344, write web=4'b1010 data 32'hAABBCCDD -> read returns 32'h11BB33DD.
REQ-034 Out of range: read or write addr 14'h0040 (DEPTH_LOG2=6) -> rsp_err=1, rsp_rdata=0, word 0 unchanged.
REQ-035 WAIT_CYCLES=0: read at edge T -> busy high only in the request cycle, rsp_valid in cycle T+1; back-to-back requests alternate IDLE/RESP.
REQ-036 Write accepted, rst pulsed during WAIT -> outputs zero, state IDLE, and a later read shows old contents.
REQ-037 req_cs held high through RESP -> that cycle ignored; new request accepted only on the next IDLE cycle.
